trap_csr: RTL
=============

TRAP_CSR -- requirements
Module: trap_csr

Interface
REQ-001 SHALL have port: clock  input  1  rising-edge clock.
REQ-002 SHALL have port: reset  input  1  reset, synchronous, active-low.
REQ-003 SHALL have port: trapTake  input  1  trap commit pulse from the hazard unit.
REQ-004 SHALL have port: trapCause  input  4  exception code (0,2,3,4,6,0xB).
REQ-005 SHALL have port: trapPc  input  32  PC of the faulting instruction.
REQ-006 SHALL have port: trapValue  input  32  faulting address or instruction, written to mtval.
REQ-007 SHALL have port: mretTake  input  1  MRET commit pulse.
REQ-008 SHALL have port: csrOp  input  2  csrOp_ value: 00 none, 01 RW, 10 RS, 11 RC.
REQ-009 SHALL have port: csrAddress  input  12  CSR address.
REQ-010 SHALL have port: csrWriteData  input  32  rs1 or zimm operand.
REQ-011 SHALL have port: csrSourceZero  input  1  operand field is x0 or zimm is 0.
REQ-012 SHALL have port: retire  input  1  one instruction retired this cycle.
REQ-013 SHALL have port: csrReadData  output  32  combinational old value of the addressed CSR.
REQ-014 SHALL have port: csrIllegal  output  1  combinational: access is illegal.
REQ-015 SHALL have port: redirectValid  output  1  registered PC redirect.
REQ-016 SHALL have port: redirectPc  output  32  redirect target.
REQ-017 SHALL have port: interruptEnable  output  1  mstatus.MIE.

Function
REQ-018 SHALL implement mstatus (0x300), mtvec (0x305), mscratch (0x340), mepc (0x341), mcause (0x342), mtval (0x343), mcycle/mcycleh (0xB00/0xB80), minstret/minstreth (0xB02/0xB82), and mhartid (0xF14, reads 0).
REQ-019 mstatus SHALL store only MIE[3] and MPIE[7]; MPP[12:11] SHALL read 2'b11; all other bits SHALL read 0.
REQ-020 mtvec SHALL support direct mode only, with bits[1:0] reading 0; mepc bits[1:0] SHALL read 0.
REQ-021 mcause SHALL read {1'b0, 27'b0, code[3:0]}.
REQ-022 A CSR write SHALL take effect at the next clock edge: RW writes the operand, RS writes old|operand, RC writes old&~operand.
REQ-023 RS or RC with csrSourceZero=1 SHALL NOT write and SHALL NOT be illegal on read-only CSRs.
REQ-024 csrIllegal SHALL be asserted when csrOp!=00 and either the address is unimplemented, or the address is 0xF14 and the op writes. An illegal access SHALL change no state.
REQ-025 On trapTake, at the next edge: mepc<=trapPc, mcause<=trapCause, mtval<=trapValue, MPIE<=MIE, MIE<=0.
REQ-026 In the cycle after a trap, redirectValid SHALL be 1 and redirectPc SHALL equal the mtvec value current at the trap edge; latency is 1 cycle.
REQ-027 On mretTake, at the next edge: MIE<=MPIE and MPIE<=1. In the following cycle redirectValid SHALL be 1 and redirectPc SHALL equal mepc.
REQ-028 redirectValid SHALL be a single-cycle pulse and SHALL be 0 otherwise.
REQ-029 Priority for simultaneous events SHALL be trapTake > mretTake > CSR write; the losing write or MRET is discarded.
REQ-030 A CSR write to mepc or mtvec in the same cycle as trapTake SHALL be discarded.
REQ-031 The 64-bit mcycle SHALL increment every cycle.
REQ-032 The 64-bit minstret SHALL increment when retire=1.
REQ-033 A CSR write to either half of a counter SHALL replace that half, and that cycle's increment SHALL be suppressed.
REQ-034 Counters SHALL wrap from 2^64-1 to 0; a low-half carry SHALL propagate to the high half in the same edge.
REQ-035 A trap SHALL NOT suppress the counter increment.
REQ-036 The FSM SHALL have states IDLE and REDIRECT. IDLE->REDIRECT on trapTake or mretTake; REDIRECT->IDLE unconditionally; a trap arriving while in REDIRECT SHALL be re-accepted and extend REDIRECT.

Reset
REQ-037 While reset=0 at a clock edge, all CSRs SHALL be 0 (mtvec=0, mepc=0, mcause=0, MIE=0, MPIE=0), counters SHALL be 0, the FSM SHALL be IDLE, and redirectValid SHALL be 0.
REQ-038 Reset asserted during REDIRECT SHALL cancel the redirect at that edge.
REQ-039 trapTake, mretTake and csrOp SHALL be ignored while reset=0.

Structure
REQ-040 The shared package SHALL hold the csrOp_ enum, the CSR address constants and the mcause code constants.
REQ-041 The block SHALL contain one sub-module, csr_counter64, holding the 64-bit counter with increment enable and independent half writes; it SHALL be instantiated twice.

Verification
REQ-042 Reset, then RW 0x305 with 0x00000103, then trapTake (cause 2, pc 0x40) -> mtvec reads 0x100; next cycle redirectValid=1, redirectPc=0x100; mepc=0x40, mcause=2.
REQ-043 RS 0x300 with 0x8, then trap, then mretTake -> after the trap MIE=0, MPIE=1; after MRET MIE=1, redirectPc=mepc.
REQ-044 RW 0xF14 -> csrIllegal=1, no state change; RS 0xF14 with csrSourceZero=1 -> csrIllegal=0, read 0.
REQ-045 RW 0xB00 with 0xFFFFFFFF and 0xB80 with 0xFFFFFFFF -> after 1 idle cycle, mcycle reads 0 and mcycleh reads 0.
REQ-046 trapTake and RW 0x341 with 0x80 in the same cycle -> mepc=trapPc.
REQ-047 Reset during REDIRECT -> redirectValid=0 at that edge; unimplemented address 0x7C0 -> csrIllegal=1.

Source files
------------

// File: rtl/trap_csr_pkg.sv
// Shared definitions for the machine-mode trap/CSR block: CSR opcodes,
// CSR addresses, exception codes and small decode helpers.
package trap_csr_pkg;

   typedef enum logic [1:0] {
      CSR_OP_NONE = 2'b00,
      CSR_OP_RW   = 2'b01,
      CSR_OP_RS   = 2'b10,
      CSR_OP_RC   = 2'b11
   } csr_op_e;

   typedef enum logic {
      ST_IDLE,
      ST_REDIRECT
   } trap_state_e;

   localparam logic [11:0] CSR_MSTATUS   = 12'h300;
   localparam logic [11:0] CSR_MTVEC     = 12'h305;
   localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
   localparam logic [11:0] CSR_MEPC      = 12'h341;
   localparam logic [11:0] CSR_MCAUSE    = 12'h342;
   localparam logic [11:0] CSR_MTVAL     = 12'h343;
   localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
   localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
   localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
   localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
   localparam logic [11:0] CSR_MHARTID   = 12'hF14;

   localparam logic [3:0] CAUSE_INSN_MISALIGNED  = 4'h0;
   localparam logic [3:0] CAUSE_ILLEGAL_INSN     = 4'h2;
   localparam logic [3:0] CAUSE_BREAKPOINT       = 4'h3;
   localparam logic [3:0] CAUSE_LOAD_MISALIGNED  = 4'h4;
   localparam logic [3:0] CAUSE_STORE_MISALIGNED = 4'h6;
   localparam logic [3:0] CAUSE_ECALL_M          = 4'hB;

   localparam logic [1:0] MSTATUS_MPP_M = 2'b11;

   function automatic logic csr_implemented(input logic [11:0] addr);
      case (addr)
         CSR_MSTATUS, CSR_MTVEC, CSR_MSCRATCH, CSR_MEPC, CSR_MCAUSE, CSR_MTVAL,
         CSR_MCYCLE, CSR_MCYCLEH, CSR_MINSTRET, CSR_MINSTRETH, CSR_MHARTID:
            csr_implemented = 1'b1;
         default:
            csr_implemented = 1'b0;
      endcase
   endfunction

   // Read-modify-write result for the three Zicsr write flavours.
   function automatic logic [31:0] csr_apply(input csr_op_e op,
                                             input logic [31:0] old_value,
                                             input logic [31:0] operand);
      case (op)
         CSR_OP_RW: csr_apply = operand;
         CSR_OP_RS: csr_apply = old_value | operand;
         CSR_OP_RC: csr_apply = old_value & ~operand;
         default:   csr_apply = old_value;
      endcase
   endfunction

endpackage

// File: rtl/csr_counter64.sv
// 64-bit free-running counter with increment enable and independently
// writable 32-bit halves; a write to either half suppresses that cycle's increment.
module csr_counter64 (
   input  logic        clock,
   input  logic        reset,
   input  logic        inc_en_i,
   input  logic        wr_lo_i,
   input  logic        wr_hi_i,
   input  logic [31:0] wr_data_i,
   output logic [63:0] count_o
);

   logic [63:0] count_q;
   logic [63:0] count_d;

   // NOTE: every path assigns count_d first so the block stays purely combinational (no latch).
   always_comb begin
      count_d = count_q;
      if (wr_lo_i) begin
         count_d[31:0] = wr_data_i;
      end else if (wr_hi_i) begin
         count_d[63:32] = wr_data_i;
      end else if (inc_en_i) begin
         count_d = count_q + 64'd1;
      end
   end

   // NOTE: sequential state uses non-blocking assignment so all flops sample the same pre-edge values.
   always_ff @(posedge clock) begin
      if (!reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;

endmodule

// File: rtl/trap_csr.sv
// Machine-mode trap CSR file: mstatus/mtvec/mepc/mcause/mtval/mscratch,
// cycle and instret counters, and a registered PC redirect on trap or MRET.
module trap_csr
   import trap_csr_pkg::*;
(
   input  logic        clock,
   input  logic        reset,
   input  logic        trapTake,
   input  logic [3:0]  trapCause,
   input  logic [31:0] trapPc,
   input  logic [31:0] trapValue,
   input  logic        mretTake,
   input  logic [1:0]  csrOp,
   input  logic [11:0] csrAddress,
   input  logic [31:0] csrWriteData,
   input  logic        csrSourceZero,
   input  logic        retire,
   output logic [31:0] csrReadData,
   output logic        csrIllegal,
   output logic        redirectValid,
   output logic [31:0] redirectPc,
   output logic        interruptEnable
);

   csr_op_e     op;
   logic        op_writes;
   logic        csr_wr_en;
   logic        mret_accept;
   logic [31:0] wr_value;

   logic        mie_q,     mie_d;
   logic        mpie_q,    mpie_d;
   logic [29:0] mtvec_q,   mtvec_d;
   logic [31:0] mscratch_q, mscratch_d;
   logic [29:0] mepc_q,    mepc_d;
   logic [3:0]  mcause_q,  mcause_d;
   logic [31:0] mtval_q,   mtval_d;

   trap_state_e state_q;
   logic        redirect_valid_q;
   logic [31:0] redirect_pc_q;

   logic [63:0] mcycle;
   logic [63:0] minstret;
   logic        unused_pc_bits;

   assign op = csr_op_e'(csrOp);

   // RS/RC with a zero operand are pure reads and may target read-only CSRs.
   assign op_writes  = (op == CSR_OP_RW) || ((op != CSR_OP_NONE) && !csrSourceZero);
   assign csrIllegal = (op != CSR_OP_NONE) &&
                       (!csr_implemented(csrAddress) ||
                        ((csrAddress == CSR_MHARTID) && op_writes));

   // MRET is only meaningful once the pipeline has settled out of a redirect.
   assign mret_accept = mretTake && (state_q == ST_IDLE);
   assign csr_wr_en   = op_writes && !csrIllegal && !trapTake && !mret_accept;
   assign wr_value    = csr_apply(op, csrReadData, csrWriteData);

   always_comb begin
      csrReadData = '0;
      case (csrAddress)
         CSR_MSTATUS:   csrReadData = {19'b0, MSTATUS_MPP_M, 3'b0, mpie_q, 3'b0, mie_q, 3'b0};
         CSR_MTVEC:     csrReadData = {mtvec_q, 2'b00};
         CSR_MSCRATCH:  csrReadData = mscratch_q;
         CSR_MEPC:      csrReadData = {mepc_q, 2'b00};
         CSR_MCAUSE:    csrReadData = {28'b0, mcause_q};
         CSR_MTVAL:     csrReadData = mtval_q;
         CSR_MCYCLE:    csrReadData = mcycle[31:0];
         CSR_MCYCLEH:   csrReadData = mcycle[63:32];
         CSR_MINSTRET:  csrReadData = minstret[31:0];
         CSR_MINSTRETH: csrReadData = minstret[63:32];
         default:       csrReadData = '0;
      endcase
   end

   always_comb begin
      mie_d      = mie_q;
      mpie_d     = mpie_q;
      mtvec_d    = mtvec_q;
      mscratch_d = mscratch_q;
      mepc_d     = mepc_q;
      mcause_d   = mcause_q;
      mtval_d    = mtval_q;
      if (trapTake) begin
         mepc_d   = trapPc[31:2];
         mcause_d = trapCause;
         mtval_d  = trapValue;
         mpie_d   = mie_q;
         mie_d    = 1'b0;
      end else if (mret_accept) begin
         mie_d  = mpie_q;
         mpie_d = 1'b1;
      end else if (csr_wr_en) begin
         case (csrAddress)
            CSR_MSTATUS: begin
               mie_d  = wr_value[3];
               mpie_d = wr_value[7];
            end
            CSR_MTVEC:    mtvec_d    = wr_value[31:2];
            CSR_MSCRATCH: mscratch_d = wr_value;
            CSR_MEPC:     mepc_d     = wr_value[31:2];
            CSR_MCAUSE:   mcause_d   = wr_value[3:0];
            CSR_MTVAL:    mtval_d    = wr_value;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         mie_q      <= 1'b0;
         mpie_q     <= 1'b0;
         mtvec_q    <= '0;
         mscratch_q <= '0;
         mepc_q     <= '0;
         mcause_q   <= '0;
         mtval_q    <= '0;
      end else begin
         mie_q      <= mie_d;
         mpie_q     <= mpie_d;
         mtvec_q    <= mtvec_d;
         mscratch_q <= mscratch_d;
         mepc_q     <= mepc_d;
         mcause_q   <= mcause_d;
         mtval_q    <= mtval_d;
      end
   end

   // Redirect targets sample the pre-edge mtvec/mepc, so a same-cycle write never leaks in.
   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q          <= ST_IDLE;
         redirect_valid_q <= 1'b0;
         redirect_pc_q    <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (trapTake) begin
                  state_q          <= ST_REDIRECT;
                  redirect_valid_q <= 1'b1;
                  redirect_pc_q    <= {mtvec_q, 2'b00};
               end else if (mretTake) begin
                  state_q          <= ST_REDIRECT;
                  redirect_valid_q <= 1'b1;
                  redirect_pc_q    <= {mepc_q, 2'b00};
               end else begin
                  redirect_valid_q <= 1'b0;
               end
            end
            ST_REDIRECT: begin
               if (trapTake) begin
                  redirect_valid_q <= 1'b1;
                  redirect_pc_q    <= {mtvec_q, 2'b00};
               end else begin
                  state_q          <= ST_IDLE;
                  redirect_valid_q <= 1'b0;
               end
            end
            default: begin
               state_q          <= ST_IDLE;
               redirect_valid_q <= 1'b0;
            end
         endcase
      end
   end

   csr_counter64 u_mcycle (
      .clock     (clock),
      .reset     (reset),
      .inc_en_i  (1'b1),
      .wr_lo_i   (csr_wr_en && (csrAddress == CSR_MCYCLE)),
      .wr_hi_i   (csr_wr_en && (csrAddress == CSR_MCYCLEH)),
      .wr_data_i (wr_value),
      .count_o   (mcycle)
   );

   csr_counter64 u_minstret (
      .clock     (clock),
      .reset     (reset),
      .inc_en_i  (retire),
      .wr_lo_i   (csr_wr_en && (csrAddress == CSR_MINSTRET)),
      .wr_hi_i   (csr_wr_en && (csrAddress == CSR_MINSTRETH)),
      .wr_data_i (wr_value),
      .count_o   (minstret)
   );

   assign unused_pc_bits  = ^trapPc[1:0];
   assign redirectValid   = redirect_valid_q;
   assign redirectPc      = redirect_pc_q;
   assign interruptEnable = mie_q;

endmodule
